// File: rtl/spi_shifter.sv
// SPI mode-0 master byte shifter: one byte out on MOSI, one byte in from MISO per WR strobe.
// SCK phases last DIVIDER clocks each; DONE marks the final high-phase cycle of a transfer.
module spi_shifter #(
  parameter int DIVIDER  = 2,
  parameter int LSBFIRST = 0
) (
  input  logic       CLKx4,
  input  logic       nRESET,
  input  logic       WR,
  input  logic [7:0] WDATA,
  input  logic       MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(DIVIDER - 1);

  state_t     r_state;
  logic [3:0] r_div;
  logic [2:0] r_cnt;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic       r_sck;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;
  logic       r_ovr;

  state_t     w_nxt_state;
  logic [3:0] w_nxt_div;
  logic [2:0] w_nxt_cnt;
  logic       w_div_end;
  logic       w_final;
  logic       w_accept;

  assign w_div_end = (r_div == DIV_LAST);
  // The last cycle of bit 7's high phase behaves as IDLE for a new WR.
  assign w_final   = (r_state == S_HIGH) && (r_cnt == 3'd7) && w_div_end;
  assign w_accept  = WR && ((r_state == S_IDLE) || w_final);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_div   = r_div;
    w_nxt_cnt   = r_cnt;
    if (w_accept) begin
      w_nxt_state = S_LOW;
      w_nxt_div   = 4'd0;
      w_nxt_cnt   = 3'd0;
    end else begin
      case (r_state)
        S_LOW: begin
          if (w_div_end) begin
            w_nxt_state = S_HIGH;
            w_nxt_div   = 4'd0;
          end else begin
            w_nxt_div = r_div + 4'd1;
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            w_nxt_div = 4'd0;
            if (r_cnt == 3'd7) begin
              w_nxt_state = S_IDLE;
            end else begin
              w_nxt_state = S_LOW;
              w_nxt_cnt   = r_cnt + 3'd1;
            end
          end else begin
            w_nxt_div = r_div + 4'd1;
          end
        end
        default: begin
          w_nxt_state = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
      r_div   <= 4'd0;
      r_cnt   <= 3'd0;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_rdata <= 8'h00;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_div   <= w_nxt_div;
      r_cnt   <= w_nxt_cnt;
      r_busy  <= (w_nxt_state != S_IDLE);
      // DONE is looked ahead so it is high during the final cycle itself.
      r_done  <= (w_nxt_state == S_HIGH) && (w_nxt_cnt == 3'd7) &&
                 (w_nxt_div == DIV_LAST);
      if (w_final) begin
        r_rdata <= r_rx;
      end
      if (w_accept) begin
        r_tx   <= WDATA;
        r_mosi <= (LSBFIRST != 0) ? WDATA[0] : WDATA[7];
        r_ovr  <= 1'b0;
        r_sck  <= 1'b0;
      end else begin
        if (WR) begin
          r_ovr <= 1'b1;
        end
        case (r_state)
          S_LOW: begin
            if (w_div_end) begin
              r_sck <= 1'b1;
              if (LSBFIRST != 0) begin
                r_rx <= {MISO, r_rx[7:1]};
              end else begin
                r_rx <= {r_rx[6:0], MISO};
              end
            end
          end
          S_HIGH: begin
            if (w_div_end) begin
              r_sck <= 1'b0;
              if (r_cnt != 3'd7) begin
                if (LSBFIRST != 0) begin
                  r_tx   <= {1'b0, r_tx[7:1]};
                  r_mosi <= r_tx[1];
                end else begin
                  r_tx   <= {r_tx[6:0], 1'b0};
                  r_mosi <= r_tx[6];
                end
              end
            end
          end
          default: begin
            r_sck <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SCK         = r_sck;
  assign MOSI        = r_mosi;
  assign RDATA       = r_rdata;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign OVR         = r_ovr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: default instance (MSB first, DIVIDER=2)
// and an LSB-first DIVIDER=1 instance, selected by sel.
module tb_spi_shifter;

  logic       clk;
  logic       nrst;
  logic       wr;
  logic [7:0] wdata;
  logic       sel;
  logic       loop;
  logic       miso_c;

  logic       sck_a, mosi_a, busy_a, done_a, ovr_a;
  logic [7:0] rdata_a;
  logic [1:0] st_a;
  logic       sck_l, mosi_l, busy_l, done_l, ovr_l;
  logic [7:0] rdata_l;
  logic [1:0] st_l;

  logic       sck, mosi, busy, done, ovr;
  logic [7:0] rdata;

  int total;
  int bad;

  logic [15:0] g_seq;
  int          g_nbits;
  int          g_done_cnt;
  int          g_done_at;
  int          g_busy_cnt;
  int          g_sck_bad;

  spi_shifter u_dut (
    .CLKx4(clk), .nRESET(nrst), .WR(wr & ~sel), .WDATA(wdata),
    .MISO(loop ? mosi_a : miso_c),
    .SCK(sck_a), .MOSI(mosi_a), .RDATA(rdata_a), .BUSY(busy_a),
    .DONE(done_a), .OVR(ovr_a), .o_dbg_state(st_a)
  );

  spi_shifter #(.DIVIDER(1), .LSBFIRST(1)) u_dut_l (
    .CLKx4(clk), .nRESET(nrst), .WR(wr & sel), .WDATA(wdata),
    .MISO(loop ? mosi_l : miso_c),
    .SCK(sck_l), .MOSI(mosi_l), .RDATA(rdata_l), .BUSY(busy_l),
    .DONE(done_l), .OVR(ovr_l), .o_dbg_state(st_l)
  );

  assign sck   = sel ? sck_l   : sck_a;
  assign mosi  = sel ? mosi_l  : mosi_a;
  assign busy  = sel ? busy_l  : busy_a;
  assign done  = sel ? done_l  : done_a;
  assign ovr   = sel ? ovr_l   : ovr_a;
  assign rdata = sel ? rdata_l : rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe WR for one cycle; returns in cycle 1 of the transfer.
  task automatic start_wr(input logic [7:0] d);
    wr = 1'b1;
    wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // Records MOSI at each SCK rise, BUSY/DONE activity and SCK shape for ncyc cycles.
  task automatic observe(input int ncyc, input int div, input int extra_at,
                         input logic [7:0] extra_d);
    logic prev_sck;
    logic exp_sck;
    g_seq = 16'h0; g_nbits = 0; g_done_cnt = 0; g_done_at = -1;
    g_busy_cnt = 0; g_sck_bad = 0; prev_sck = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (sck && !prev_sck) begin
        g_seq = {g_seq[14:0], mosi};
        g_nbits++;
      end
      exp_sck = (((k - 1) / div) % 2) == 1;
      if (sck !== exp_sck) g_sck_bad++;
      if (busy === 1'b1) g_busy_cnt++;
      if (done === 1'b1) begin
        g_done_cnt++;
        g_done_at = k;
      end
      prev_sck = sck;
      if (k == extra_at) begin
        wr = 1'b1;
        wdata = extra_d;
      end
      @(posedge clk); #1;
      wr = 1'b0;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #3;
    total++;
    if ({sck_a, mosi_a, busy_a, done_a, ovr_a, rdata_a, st_a} !== 13'h0) begin
      bad++;
      $display("FAIL reset_a: got sck=%b mosi=%b busy=%b done=%b ovr=%b rdata=%h st=%0d want all 0",
               sck_a, mosi_a, busy_a, done_a, ovr_a, rdata_a, st_a);
    end
    total++;
    if ({sck_l, mosi_l, busy_l, done_l, ovr_l, rdata_l, st_l} !== 13'h0) begin
      bad++;
      $display("FAIL reset_l: got sck=%b busy=%b done=%b rdata=%h st=%0d want all 0",
               sck_l, busy_l, done_l, rdata_l, st_l);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback_a5;
    sel = 1'b0; loop = 1'b1;
    start_wr(8'hA5);
    observe(33, 2, 0, 8'h00);
    total++;
    if (g_nbits != 8 || g_seq[7:0] !== 8'hA5) begin
      bad++;
      $display("FAIL a5_mosi_seq: got %h (%0d bits) want a5 (8 bits)", g_seq[7:0], g_nbits);
    end
    total++;
    if (g_sck_bad != 0) begin
      bad++;
      $display("FAIL a5_sck_shape: got %0d bad cycles want 0", g_sck_bad);
    end
    total++;
    if (g_done_cnt != 1 || g_done_at != 32) begin
      bad++;
      $display("FAIL a5_done: got count=%0d at=%0d want count=1 at=32", g_done_cnt, g_done_at);
    end
    total++;
    if (rdata !== 8'hA5 || busy !== 1'b0 || mosi !== 1'b1) begin
      bad++;
      $display("FAIL a5_end: got rdata=%h busy=%b mosi=%b want a5 0 1", rdata, busy, mosi);
    end
  endtask

  task automatic test_miso_high;
    sel = 1'b0; loop = 1'b0; miso_c = 1'b1;
    start_wr(8'h00);
    observe(33, 2, 0, 8'h00);
    total++;
    if (g_busy_cnt != 32) begin
      bad++;
      $display("FAIL ff_busy_len: got %0d want 32", g_busy_cnt);
    end
    total++;
    if (g_done_cnt != 1) begin
      bad++;
      $display("FAIL ff_done_cnt: got %0d want 1", g_done_cnt);
    end
    total++;
    if (rdata !== 8'hFF || mosi !== 1'b0) begin
      bad++;
      $display("FAIL ff_rdata: got rdata=%h mosi=%b want ff 0", rdata, mosi);
    end
  endtask

  task automatic test_overrun;
    sel = 1'b0; loop = 1'b1;
    start_wr(8'h3C);
    observe(33, 2, 10, 8'hFF);
    total++;
    if (g_seq[7:0] !== 8'h3C || g_nbits != 8) begin
      bad++;
      $display("FAIL ovr_mosi_seq: got %h (%0d bits) want 3c", g_seq[7:0], g_nbits);
    end
    total++;
    if (ovr !== 1'b1 || rdata !== 8'h3C) begin
      bad++;
      $display("FAIL ovr_sticky: got ovr=%b rdata=%h want 1 3c", ovr, rdata);
    end
    start_wr(8'h00);
    total++;
    if (ovr !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ovr_clear: got ovr=%b busy=%b want 0 1", ovr, busy);
    end
    observe(32, 2, 0, 8'h00);
  endtask

  task automatic test_back_to_back;
    sel = 1'b0; loop = 1'b1;
    start_wr(8'h5A);
    observe(65, 2, 32, 8'h81);
    total++;
    if (g_busy_cnt != 64) begin
      bad++;
      $display("FAIL b2b_busy: got %0d busy cycles want 64", g_busy_cnt);
    end
    total++;
    if (g_nbits != 16 || g_seq !== 16'h5A81) begin
      bad++;
      $display("FAIL b2b_mosi_seq: got %h (%0d bits) want 5a81", g_seq, g_nbits);
    end
    total++;
    if (g_done_cnt != 2 || g_done_at != 64 || ovr !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: got count=%0d at=%0d ovr=%b want 2 64 0", g_done_cnt, g_done_at, ovr);
    end
    total++;
    if (rdata !== 8'h81 || g_sck_bad != 0) begin
      bad++;
      $display("FAIL b2b_rdata: got rdata=%h sck_bad=%0d want 81 0", rdata, g_sck_bad);
    end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; loop = 1'b1;
    start_wr(8'hC3);
    observe(11, 2, 0, 8'h00);
    nrst = 1'b0;
    #1;
    total++;
    if (sck !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00 || done !== 1'b0 || st_a !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: got sck=%b busy=%b rdata=%h done=%b st=%0d want 0 0 00 0 0",
               sck, busy, rdata, done, st_a);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    observe(4, 2, 0, 8'h00);
    total++;
    if (g_done_cnt != 0 || g_busy_cnt != 0) begin
      bad++;
      $display("FAIL mid_no_done: got done=%0d busy=%0d want 0 0", g_done_cnt, g_busy_cnt);
    end
    start_wr(8'h96);
    observe(33, 2, 0, 8'h00);
    total++;
    if (rdata !== 8'h96 || g_done_cnt != 1 || g_done_at != 32) begin
      bad++;
      $display("FAIL mid_restart: got rdata=%h done=%0d at=%0d want 96 1 32", rdata, g_done_cnt, g_done_at);
    end
  endtask

  task automatic test_lsb_first;
    sel = 1'b1; loop = 1'b1;
    start_wr(8'h01);
    total++;
    if (mosi !== 1'b1) begin
      bad++;
      $display("FAIL lsb_first_bit: got %b want 1", mosi);
    end
    observe(17, 1, 0, 8'h00);
    total++;
    if (g_nbits != 8 || g_seq[7:0] !== 8'h80) begin
      bad++;
      $display("FAIL lsb_mosi_seq: got %h (%0d bits) want 80", g_seq[7:0], g_nbits);
    end
    total++;
    if (g_busy_cnt != 16 || g_done_at != 16 || g_done_cnt != 1 || g_sck_bad != 0) begin
      bad++;
      $display("FAIL lsb_timing: got busy=%0d done_at=%0d done=%0d sck_bad=%0d want 16 16 1 0",
               g_busy_cnt, g_done_at, g_done_cnt, g_sck_bad);
    end
    total++;
    if (rdata !== 8'h01) begin
      bad++;
      $display("FAIL lsb_rdata: got %h want 01", rdata);
    end
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL lsb_isolation: got busy_a=%b done_a=%b want 0 0", busy_a, done_a);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    wr = 1'b0; wdata = 8'h00; sel = 1'b0; loop = 1'b1; miso_c = 1'b0; nrst = 1'b1;
    #2;
    test_reset();
    test_loopback_a5();
    test_miso_high();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_lsb_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 SHALL have parameter DIVIDER, default 2: SCK half-period in CLKx4 cycles, legal 1..15.
REQ-002 SHALL have parameter LSBFIRST, default 0: 0 = MSB first, 1 = LSB first.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port CLKx4  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port nRESET  input  1  asynchronous active-low reset.
REQ-006 SHALL have port WR  input  1  start strobe from the ctrl decoder, sampled each clock.
REQ-007 SHALL have port WDATA  input  8  byte to transmit, valid with WR.
REQ-008 SHALL have port MISO  input  1  serial data from the selected SPI device.
REQ-009 SHALL have port SCK  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port MOSI  output  1  serial data to the device.
REQ-011 SHALL have port RDATA  output  8  last fully received byte.
REQ-012 SHALL have port BUSY  output  1  transfer in progress.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at transfer completion.
REQ-014 SHALL have port OVR  output  1  sticky: WR arrived while BUSY.

Function
REQ-015 SHALL implement states IDLE, LOW (SCK=0) and HIGH (SCK=1).
REQ-016 IDLE + WR: SHALL load WDATA into the shift register, clear bit counter and divider counter, clear OVR, and enter LOW; BUSY=1 from the next cycle.
REQ-017 SHALL drive MOSI from the current transmit bit (bit7, or bit0 if LSBFIRST) from the cycle after the load, giving at least DIVIDER cycles of setup before the first SCK rise.
REQ-018 LOW: after DIVIDER cycles SHALL set SCK=1, register MISO into the receive shift register on that same edge, and enter HIGH.
REQ-019 HIGH: after DIVIDER cycles SHALL set SCK=0; bits 0..6 SHALL shift the transmit register, increment the 3-bit counter, and return to LOW.
REQ-020 HIGH with counter=7: SHALL set SCK=0, copy the receive register to RDATA, pulse DONE, clear BUSY, and enter IDLE, all in the same cycle.
REQ-021 Total transfer SHALL take exactly 16*DIVIDER cycles from the first BUSY=1 cycle to the DONE cycle inclusive.
REQ-022 Receive bit order SHALL match LOSBFIRST: first sampled bit lands in RDATA[7], or in RDATA[0] if LSBFIRST=1.
REQ-023 WR while BUSY=1: SHALL be ignored for data and SHALL set OVR; the transfer continues unchanged.
REQ-024 WR in the DONE cycle: SHALL be accepted as a new start (IDLE is entered combinationally); DONE and the new load SHALL coexist, and BUSY SHALL stay 1 continuously.
REQ-025 MOSI SHALL hold the last transmitted bit in IDLE; SCK SHALL be 0 in IDLE.
REQ-026 RDATA SHALL change only in the DONE cycle or on reset.
REQ-027 Divider counter SHALL be 4 bits and reload at 0 on every SCK edge; it SHALL never wrap mid-phase.

Reset
REQ-028 nRESET=0 SHALL asynchronously force state IDLE, SCK=0, MOSI=0, BUSY=0, DONE=0, OVR=0, RDATA=8'h00, and clear shift registers and counters.
REQ-029 Reset mid-transfer SHALL abort the transfer without a DONE pulse; RDATA SHALL read 8'h00.
REQ-030 The first WR after reset release SHALL start a normal transfer.

Verification
REQ-031 DIVIDER=2, WR with WDATA=8'hA5, MISO loops back from MOSI -> MOSI sequence 1,0,1,0,0,1,0,1; 8 SCK pulses each 2 high/2 low; DONE at cycle 32; RDATA=8'hA5.
REQ-032 MISO tied to 1, WDATA=8'h00 -> RDATA=8'hFF, DONE pulses once for 1 cycle, BUSY high for exactly 32 cycles.
REQ-033 WR with 8'h3C, second WR with 8'hFF at cycle 10 -> OVR=1, MOSI still transmits 8'h3C; the next accepted WR clears OVR.
REQ-034 WR in the DONE cycle with 8'h81 -> BUSY stays 1 with no gap, the second byte transmits 1,0,0,0,0,0,0,1.
REQ-035 nRESET asserted at cycle 12 of a transfer -> SCK=0, BUSY=0, RDATA=8'h00 immediately, no DONE; a new WR after release completes normally.
REQ-036 LSBFIRST=1, DIVIDER=1, WDATA=8'h01, loopback -> MOSI first bit 1, transfer takes 16 cycles, RDATA=8'h01.
